// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline sequencing controller: stall masks, FSM states, reset level.
// No logic; imported by pipe_ctrl and pipe_div_timer.
package pipe_ctrl_pkg;

  localparam logic        RST_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

  // Bit order: [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]WB, 1 = hold
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DIV_WAIT = 2'd2,
    ST_FLUSH    = 2'd3
  } state_t;

endpackage

// File: rtl/pipe_div_timer.sv
// Saturating divide-wait cycle counter; expired is combinational from the count register.
// clr has priority over en; the count holds once it reaches MAX.
module pipe_div_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX = 40
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || clr) begin
      cnt <= '0;
    end else if (en && cnt != W'(MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == W'(MAX));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/divider sequencer; every output is registered, so a decision shows one cycle later.
// Stall sources are merged by priority (exception > memory wait > divide > load-use); requesters hold until served.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_TIMEOUT = 40,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_stallreq,
  input  logic             ex_div_req,
  input  logic             ex_div_done,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             excp_valid,
  input  logic [31:0]      excp_pc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             div_grant,
  output logic             div_cancel,
  output logic             div_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  state_t      state, state_nxt;
  logic [5:0]  stall_nxt;
  logic        flush_nxt;
  logic [31:0] new_pc_nxt;
  logic        grant_nxt;
  logic        cancel_nxt;
  logic        timeout_set;
  logic        tmr_clr;
  logic        tmr_en;
  logic        tmr_expired;

  pipe_div_timer #(
    .MAX(DIV_TIMEOUT)
  ) u_div_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(tmr_expired)
  );

  always_comb begin
    state_nxt   = state;
    stall_nxt   = STALL_NONE;
    flush_nxt   = 1'b0;
    new_pc_nxt  = new_pc;
    grant_nxt   = 1'b0;
    cancel_nxt  = 1'b0;
    timeout_set = 1'b0;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;

    case (state)
      ST_RUN: begin
        if (excp_valid) begin
          state_nxt  = ST_FLUSH;
          flush_nxt  = 1'b1;
          new_pc_nxt = excp_pc;
        end else if (mem_req && !mem_ack) begin
          state_nxt = ST_MEM_WAIT;
          stall_nxt = STALL_MEM;
        end else if (ex_div_req) begin
          state_nxt = ST_DIV_WAIT;
          stall_nxt = STALL_EX;
          grant_nxt = 1'b1;
          tmr_clr   = 1'b1;
        end else if (id_stallreq) begin
          stall_nxt = STALL_ID;
        end
      end

      ST_MEM_WAIT: begin
        // A late mem_ack after an exception is dropped because FLUSH ignores inputs.
        if (excp_valid) begin
          state_nxt  = ST_FLUSH;
          flush_nxt  = 1'b1;
          new_pc_nxt = excp_pc;
        end else if (mem_ack) begin
          state_nxt = ST_RUN;
        end else begin
          stall_nxt = STALL_MEM;
        end
      end

      ST_DIV_WAIT: begin
        if (excp_valid) begin
          state_nxt  = ST_FLUSH;
          flush_nxt  = 1'b1;
          new_pc_nxt = excp_pc;
          cancel_nxt = 1'b1;
        end else if (ex_div_done) begin
          state_nxt = ST_RUN;
        end else if (tmr_expired) begin
          state_nxt   = ST_RUN;
          cancel_nxt  = 1'b1;
          timeout_set = 1'b1;
        end else begin
          stall_nxt = STALL_EX;
          tmr_en    = 1'b1;
        end
      end

      ST_FLUSH: begin
        state_nxt = ST_RUN;
      end

      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state        <= ST_RUN;
      stall        <= STALL_NONE;
      flush        <= 1'b0;
      new_pc       <= ZERO_WORD;
      div_grant    <= 1'b0;
      div_cancel   <= 1'b0;
      div_timeout  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state        <= state_nxt;
      stall        <= stall_nxt;
      flush        <= flush_nxt;
      new_pc       <= new_pc_nxt;
      div_grant    <= grant_nxt;
      div_cancel   <= cancel_nxt;
      div_timeout  <= div_timeout | timeout_set;
      stall_cycles <= stall_cycles + CNT_W'(stall != STALL_NONE);
    end
  end

endmodule
